// File: rtl/sram_copy_engine.sv
// Simple DMA initiator for the single-port sram: block copy or constant fill of len words,
// with an XOR checksum of every word written. All outputs come from registers.
module sram_copy_engine #(
   parameter int unsigned addr_width = 16,
   parameter int unsigned data_width = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [addr_width-1:0] src_addr,
   input  logic [addr_width-1:0] dst_addr,
   input  logic [addr_width-1:0] len,
   input  logic [data_width-1:0] fill_value,
   output logic                  busy,
   output logic                  done,
   output logic [data_width-1:0] checksum,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [addr_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_wr_data,
   input  logic [data_width-1:0] mem_rd_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state, state_d;
   logic [addr_width-1:0] cnt, cnt_d;
   logic                  mode_q, mode_d;
   logic [addr_width-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic [data_width-1:0] fill_q, fill_d, data_q, data_d, checksum_d;
   logic                  busy_d, done_d, en_d, we_d;
   logic [addr_width-1:0] addr_d;
   logic [data_width-1:0] wr_data_d;

   // Next state, then the Moore outputs of that next state so they register alongside it.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      mode_d     = mode_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      fill_d     = fill_q;
      data_d     = data_q;
      checksum_d = checksum;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      en_d       = 1'b0;
      we_d       = 1'b0;
      addr_d     = '0;
      wr_data_d  = '0;

      case (state)
         IDLE: begin
            if (start) begin
               mode_d     = mode;
               src_d      = src_addr;
               dst_d      = dst_addr;
               len_d      = len;
               fill_d     = fill_value;
               cnt_d      = '0;
               checksum_d = '0;
               if (len == '0)  state_d = DONE;
               else if (mode)  state_d = WRITE;
               else            state_d = READ;
            end
         end
         READ: begin
            data_d  = mem_rd_data;
            state_d = WRITE;
         end
         WRITE: begin
            checksum_d = checksum ^ mem_wr_data;
            if (cnt == len_q - addr_width'(1)) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt + addr_width'(1);
               state_d = mode_q ? WRITE : READ;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      case (state_d)
         READ: begin
            en_d   = 1'b1;
            addr_d = src_d + cnt_d;
         end
         WRITE: begin
            en_d      = 1'b1;
            we_d      = 1'b1;
            addr_d    = dst_d + cnt_d;
            wr_data_d = mode_d ? fill_d : data_d;
         end
         DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         mode_q      <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         fill_q      <= '0;
         data_q      <= '0;
         checksum    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         mode_q      <= mode_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         fill_q      <= fill_d;
         data_q      <= data_d;
         checksum    <= checksum_d;
         busy        <= busy_d;
         done        <= done_d;
         mem_en      <= en_d;
         mem_we      <= we_d;
         mem_addr    <= addr_d;
         mem_wr_data <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_sram_copy_engine.sv
// Directed bench for sram_copy_engine with a behavioural sram (negedge write, combinational read).
module tb_sram_copy_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] src_addr = '0, dst_addr = '0, len = '0;
   logic [31:0] fill_value = '0;
   logic        busy, done, mem_en, mem_we;
   logic [31:0] checksum, mem_wr_data, mem_rd_data;
   logic [15:0] mem_addr;

   logic [31:0] mem [65536];
   int vectors = 0;
   int errors  = 0;

   sram_copy_engine #(.addr_width(16), .data_width(32)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
      .busy(busy), .done(done), .checksum(checksum),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   assign mem_rd_data = mem[mem_addr];
   always @(negedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wr_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one start; report the cycle offset of done, writes seen and whether busy stayed high.
   // poke_k > 0 pulses start with unrelated operands in that cycle.
   task automatic run_op(input logic m, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [31:0] f, input int poke_k,
                         output int done_at, output int we_cnt, output bit busy_ok);
      @(negedge clk);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f;
      @(posedge clk);
      #1 start = 1'b0;
      done_at = -1; we_cnt = 0; busy_ok = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (mem_we) we_cnt++;
         if (!busy) busy_ok = 1'b0;
         if (done) begin done_at = k; break; end
         if (k == poke_k) begin
            start = 1'b1; mode = 1'b1; src_addr = 16'h0; dst_addr = 16'h500;
            len = 16'd2; fill_value = 32'hFFFF;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   int  done_at, we_cnt;
   bit  busy_ok;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[16'h10] = 32'h11; mem[16'h11] = 32'h22; mem[16'h12] = 32'h33; mem[16'h13] = 32'h44;
      mem[16'h203] = 32'h12345678;
      for (int i = 0; i < 4; i++) mem[16'h300 + i] = 32'hAAAA0000 + 32'(i);
      mem[16'h500] = 32'hCAFE0000;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_en", 32'(mem_en), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wr_data, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      rst = 1'b0;

      // copy 4 words 0x10 -> 0x80
      run_op(1'b0, 16'h10, 16'h80, 16'd4, 32'h0, 0, done_at, we_cnt, busy_ok);
      check("copy_done_at", 32'(done_at), 32'd9);
      check("copy_writes", 32'(we_cnt), 32'd4);
      check("copy_busy", 32'(busy_ok), 32'd1);
      check("copy_checksum", checksum, 32'h44);
      check("copy_m80", mem[16'h80], 32'h11);
      check("copy_m81", mem[16'h81], 32'h22);
      check("copy_m82", mem[16'h82], 32'h33);
      check("copy_m83", mem[16'h83], 32'h44);

      // fill 3 words at 0x200
      run_op(1'b1, 16'h0, 16'h200, 16'd3, 32'hDEADBEEF, 0, done_at, we_cnt, busy_ok);
      check("fill_done_at", 32'(done_at), 32'd4);
      check("fill_checksum", checksum, 32'hDEADBEEF);
      check("fill_m200", mem[16'h200], 32'hDEADBEEF);
      check("fill_m201", mem[16'h201], 32'hDEADBEEF);
      check("fill_m202", mem[16'h202], 32'hDEADBEEF);
      check("fill_m203", mem[16'h203], 32'h12345678);

      // zero-length copy
      run_op(1'b0, 16'h10, 16'h90, 16'd0, 32'h0, 0, done_at, we_cnt, busy_ok);
      check("len0_done_at", 32'(done_at), 32'd1);
      check("len0_writes", 32'(we_cnt), 32'd0);
      check("len0_checksum", checksum, 32'd0);
      check("len0_m90", mem[16'h90], 32'd0);

      // fill across the top of the address space
      run_op(1'b1, 16'h0, 16'hFFFE, 16'd4, 32'h5, 0, done_at, we_cnt, busy_ok);
      check("wrap_done_at", 32'(done_at), 32'd5);
      check("wrap_checksum", checksum, 32'd0);
      check("wrap_mfffe", mem[16'hFFFE], 32'h5);
      check("wrap_mffff", mem[16'hFFFF], 32'h5);
      check("wrap_m0000", mem[16'h0000], 32'h5);
      check("wrap_m0001", mem[16'h0001], 32'h5);

      // reset during the second WRITE of a 4-word copy
      @(negedge clk);
      start = 1'b1; mode = 1'b0; src_addr = 16'h10; dst_addr = 16'h300; len = 16'd4;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check("rstmid_we_cycle4", 32'(mem_we), 32'd1);
      check("rstmid_addr_cycle4", 32'(mem_addr), 32'h301);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_done", 32'(done), 32'd0);
      check("rstmid_en", 32'(mem_en), 32'd0);
      check("rstmid_we", 32'(mem_we), 32'd0);
      check("rstmid_addr", 32'(mem_addr), 32'd0);
      check("rstmid_wdata", mem_wr_data, 32'd0);
      check("rstmid_checksum", checksum, 32'd0);
      rst = 1'b0;
      we_cnt = 0; done_at = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_we || mem_en) we_cnt++;
         if (done) done_at++;
      end
      check("rstmid_no_access", 32'(we_cnt), 32'd0);
      check("rstmid_no_done", 32'(done_at), 32'd0);
      check("rstmid_m300", mem[16'h300], 32'h11);
      check("rstmid_m301", mem[16'h301], 32'h22);
      check("rstmid_m302", mem[16'h302], 32'hAAAA0002);
      check("rstmid_m303", mem[16'h303], 32'hAAAA0003);

      // start pulsed mid-copy must be ignored
      run_op(1'b0, 16'h10, 16'h400, 16'd4, 32'h0, 3, done_at, we_cnt, busy_ok);
      check("ign_done_at", 32'(done_at), 32'd9);
      check("ign_writes", 32'(we_cnt), 32'd4);
      check("ign_checksum", checksum, 32'h44);
      check("ign_m400", mem[16'h400], 32'h11);
      check("ign_m403", mem[16'h403], 32'h44);
      check("ign_m500", mem[16'h500], 32'hCAFE0000);

      // next start from IDLE clears the checksum
      run_op(1'b1, 16'h0, 16'h600, 16'd1, 32'h77, 0, done_at, we_cnt, busy_ok);
      check("next_done_at", 32'(done_at), 32'd2);
      check("next_checksum", checksum, 32'h77);
      check("next_m600", mem[16'h600], 32'h77);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
